// File: rtl/tensor_adder_scheduler_pkg.sv
// Shared constants and the in-flight tag record for the tensor add/sub scheduler.
// Stage indices refer to the shadow tag pipeline that mirrors the adder's float path.
package tensor_adder_scheduler_pkg;

    localparam int FLOAT_LATENCY   = 3;
    localparam int TAG_ADDER_STAGE = 0;
    localparam int TAG_OUT_STAGE   = 2;
    localparam int TAG_ID_MAX_W    = 8;

    typedef struct packed {
        logic                    valid;
        logic [TAG_ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/tensor_adder_scheduler_if.sv
// Bus between the scheduler (master) and the shared tensor scalar add/sub unit (slave).
interface tensor_adder_scheduler_if #(
    parameter int BW_TENSOR_SCALAR = 32
);

    logic                        add_enable;
    logic                        add_in_valid;
    logic                        add_is_sub;
    logic                        add_is_float;
    logic [BW_TENSOR_SCALAR-1:0] add_input0;
    logic [BW_TENSOR_SCALAR-1:0] add_input1;
    logic                        add_out_valid;
    logic [BW_TENSOR_SCALAR-1:0] add_out_result;

    modport master (
        output add_enable, add_in_valid, add_is_sub, add_is_float, add_input0, add_input1,
        input  add_out_valid, add_out_result
    );

    modport slave (
        input  add_enable, add_in_valid, add_is_sub, add_is_float, add_input0, add_input1,
        output add_out_valid, add_out_result
    );

endinterface

// File: rtl/tensor_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after ptr wins.
// Purely combinational so a scheduler can gate eligibility in the same cycle.
module tensor_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BW_ID   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [BW_ID-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [BW_ID-1:0]   grant_id,
    output logic               grant_valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        // Walk from the far end back toward ptr so the closest eligible entry wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_id    = idx[BW_ID-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tensor_adder_scheduler.sv
// Shares one add/sub unit (0-cycle int path, 3-stage float path) among NUM_REQ requesters
// and returns each result with its requester id through a registered valid/ready channel.
module tensor_adder_scheduler
    import tensor_adder_scheduler_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int BW_ID            = 2,
    parameter int BW_TENSOR_SCALAR = 32
) (
    input  logic                                clk,
    input  logic                                rstp,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_is_sub,
    input  logic [NUM_REQ-1:0]                  req_is_float,
    input  logic [NUM_REQ*BW_TENSOR_SCALAR-1:0] req_input0,
    input  logic [NUM_REQ*BW_TENSOR_SCALAR-1:0] req_input1,
    tensor_adder_scheduler_if.master            add_if,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [BW_ID-1:0]                    rsp_id,
    output logic [BW_TENSOR_SCALAR-1:0]         rsp_result
);

    tag_t                        tag_q [FLOAT_LATENCY];
    tag_t                        tag_d [FLOAT_LATENCY];
    logic [BW_ID-1:0]            ptr_q, ptr_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [BW_ID-1:0]            rsp_id_q, rsp_id_d;
    logic [BW_TENSOR_SCALAR-1:0] rsp_result_q, rsp_result_d;

    logic                        add_enable, int_block, any_tag, gnt_float;
    logic [NUM_REQ-1:0]          eligible, grant;
    logic [BW_ID-1:0]            grant_id;
    logic                        grant_valid;
    logic                        unused_tag_id;

    assign add_enable    = ~rsp_valid_q | rsp_ready;
    assign int_block     = tag_q[TAG_ADDER_STAGE].valid | tag_q[TAG_OUT_STAGE].valid;
    assign unused_tag_id = ^tag_q[TAG_OUT_STAGE].id;

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i < FLOAT_LATENCY; i++) any_tag = any_tag | tag_q[i].valid;
    end

    // Floats only need the adder to be enabled; ints must also dodge the shared adder and output mux.
    assign eligible = req_valid & (req_is_float | {NUM_REQ{~int_block}})
                    & {NUM_REQ{add_enable & ~rstp}};

    tensor_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BW_ID   (BW_ID)
    ) u_arbiter (
        .eligible    (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign gnt_float           = req_is_float[grant_id];
    assign req_ready           = grant;
    assign add_if.add_enable   = add_enable;
    assign add_if.add_in_valid = grant_valid;
    assign add_if.add_is_sub   = grant_valid & req_is_sub[grant_id];
    assign add_if.add_is_float = grant_valid ? gnt_float : any_tag;
    assign add_if.add_input0   = req_input0[int'(grant_id)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
    assign add_if.add_input1   = req_input1[int'(grant_id)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];

    always_comb begin
        tag_d        = tag_q;
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        if (add_enable) begin
            tag_d[0].valid = grant_valid & gnt_float;
            tag_d[0].id    = TAG_ID_MAX_W'(grant_id);
            for (int i = 1; i < FLOAT_LATENCY; i++) tag_d[i] = tag_q[i-1];
        end

        if (grant_valid) begin
            ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + BW_ID'(1);
        end

        // An emerging float owns the output mux, so its id comes from the tag, not the grant.
        if (add_if.add_out_valid && add_enable) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = tag_q[TAG_OUT_STAGE].valid ? tag_q[TAG_OUT_STAGE].id[BW_ID-1:0] : grant_id;
            rsp_result_d = add_if.add_out_result;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments only; the tag array is small control state, so it is reset.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            for (int i = 0; i < FLOAT_LATENCY; i++) tag_q[i] <= '0;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            tag_q        <= tag_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_tensor_adder_scheduler.sv
// Directed bench for tensor_adder_scheduler with a behavioural shared add/sub unit.
module tb_tensor_adder_scheduler;

    localparam int NUM_REQ = 4;
    localparam int BW_ID   = 2;
    localparam int BW      = 32;

    logic                  clk = 1'b0;
    logic                  rstp;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_is_sub, req_is_float;
    logic [NUM_REQ*BW-1:0] req_input0, req_input1;
    logic                  rsp_valid, rsp_ready;
    logic [BW_ID-1:0]      rsp_id;
    logic [BW-1:0]         rsp_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tensor_adder_scheduler_if #(.BW_TENSOR_SCALAR(BW)) add_bus ();

    tensor_adder_scheduler #(
        .NUM_REQ          (NUM_REQ),
        .BW_ID            (BW_ID),
        .BW_TENSOR_SCALAR (BW)
    ) dut (
        .clk          (clk),
        .rstp         (rstp),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_sub   (req_is_sub),
        .req_is_float (req_is_float),
        .req_input0   (req_input0),
        .req_input1   (req_input1),
        .add_if       (add_bus),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result)
    );

    // Positive normal float32 add, truncating; enough for the vectors used here.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        logic [7:0]  ea, eb;
        logic [24:0] ma, mb, s;
        if (a[30:23] < b[30:23]) begin
            t = a; a = b; b = t;
        end
        ea = a[30:23];
        eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]} >> (ea - eb);
        s  = ma + mb;
        if (s[24]) begin
            s  = s >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, s[22:0]};
    endfunction

    // Adder model: 3 enabled float stages, combinational integer path sharing the output.
    logic [2:0]    s_v;
    logic [BW-1:0] s_r [3];

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            s_v <= '0;
            for (int i = 0; i < 3; i++) s_r[i] <= '0;
        end else if (add_bus.add_enable) begin
            s_v    <= {s_v[1:0], add_bus.add_in_valid & add_bus.add_is_float};
            s_r[0] <= fadd(add_bus.add_input0, add_bus.add_input1);
            s_r[1] <= s_r[0];
            s_r[2] <= s_r[1];
        end
    end

    assign add_bus.add_out_valid  = s_v[2] | (add_bus.add_in_valid & ~add_bus.add_is_float);
    assign add_bus.add_out_result = s_v[2] ? s_r[2] :
                                    add_bus.add_is_sub ? add_bus.add_input0 - add_bus.add_input1 :
                                                         add_bus.add_input0 + add_bus.add_input1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic flt, input logic sub,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]          = 1'b1;
        req_is_float[i]       = flt;
        req_is_sub[i]         = sub;
        req_input0[i*BW +: BW] = a;
        req_input1[i*BW +: BW] = b;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [31:0] res);
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_id"}, 32'(rsp_id), id);
        check({tag, "_result"}, rsp_result, res);
    endtask

    // The float pipeline must keep the adder in float mode while it owns the adder or the output.
    always @(negedge clk) begin
        #2;
        if (!rstp && (s_v[0] || s_v[2])) check("mode_hold", 32'(add_bus.add_is_float), 1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstp = 1'b1;
        req_valid = '0; req_is_sub = '0; req_is_float = '0;
        req_input0 = '0; req_input1 = '0;
        rsp_ready = 1'b1;

        // Reset: a pending request is refused.
        set_req(0, 1'b0, 1'b0, 32'd5, 32'd7);
        step(); #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_in_valid", 32'(add_bus.add_in_valid), 0);

        // Int smoke: 5 + 7 on req0.
        step(); rstp = 1'b0; #1;
        check("int_grant", 32'(req_ready), 32'h1);
        check("int_in_valid", 32'(add_bus.add_in_valid), 1);
        check("int_mode", 32'(add_bus.add_is_float), 0);
        step(); clr_req(0); #1;
        check_rsp("int_rsp", 0, 32'd12);
        step(); #1;
        check("int_drain", 32'(rsp_valid), 0);

        // Float smoke: 1.5 + 2.25 on req1, result 4 cycles after grant.
        step(); set_req(1, 1'b1, 1'b0, 32'h3FC0_0000, 32'h4010_0000); #1;
        check("flt_grant", 32'(req_ready), 32'h2);
        check("flt_mode", 32'(add_bus.add_is_float), 1);
        for (int k = 1; k <= 3; k++) begin
            step(); if (k == 1) clr_req(1); #1;
            check($sformatf("flt_wait%0d", k), 32'(rsp_valid), 0);
            check($sformatf("flt_mode%0d", k), 32'(add_bus.add_is_float), 1);
        end
        step(); #1;
        check_rsp("flt_rsp", 1, 32'h4070_0000);
        step(); #1;
        check("flt_drain", 32'(rsp_valid), 0);

        // Hazard: float req2 at h, int req3 blocked at h+1/h+3, granted at h+2 and h+4.
        step(); set_req(2, 1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000); #1;
        check("hz_flt_grant", 32'(req_ready), 32'h4);
        step(); clr_req(2); set_req(3, 1'b0, 1'b0, 32'd20, 32'd22); #1;
        check("hz_block_t0", 32'(req_ready), 0);
        check("hz_mode_t0", 32'(add_bus.add_is_float), 1);
        check("hz_idle_t0", 32'(add_bus.add_in_valid), 0);
        step(); #1;
        check("hz_int_grant", 32'(req_ready), 32'h8);
        check("hz_int_mode", 32'(add_bus.add_is_float), 0);
        step(); set_req(3, 1'b0, 1'b1, 32'd9, 32'd4); #1;
        check("hz_block_t2", 32'(req_ready), 0);
        check("hz_mode_t2", 32'(add_bus.add_is_float), 1);
        check_rsp("hz_int_rsp", 3, 32'd42);
        step(); #1;
        check("hz_int2_grant", 32'(req_ready), 32'h8);
        check_rsp("hz_flt_rsp", 2, 32'h4000_0000);
        step(); clr_req(3); #1;
        check_rsp("hz_int2_rsp", 3, 32'd5);
        step(); #1;
        check("hz_drain", 32'(rsp_valid), 0);

        // Fairness: all four int requesters continuously; drain and capture every cycle.
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, 32'(i * 10), 32'd1);
            #1;
            check($sformatf("rr_grant%0d", k), 32'(req_ready), 1 << (k % 4));
            if (k > 0) check_rsp($sformatf("rr_rsp%0d", k), (k - 1) % 4, 32'(((k - 1) % 4) * 10 + 1));
        end
        step(); for (int i = 0; i < NUM_REQ; i++) clr_req(i); #1;
        check_rsp("rr_last", 3, 32'd31);
        step(); #1;
        check("rr_drain", 32'(rsp_valid), 0);

        // Back-pressure: floats A (req0) and B (req1); freeze with A held and B in T1.
        step(); set_req(0, 1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000); #1;
        check("bp_a_grant", 32'(req_ready), 32'h1);
        step(); clr_req(0);
        step(); set_req(1, 1'b1, 1'b0, 32'h3FC0_0000, 32'h4010_0000); #1;
        check("bp_b_grant", 32'(req_ready), 32'h2);
        step(); clr_req(1); #1;
        check("bp_pre", 32'(rsp_valid), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                rsp_ready = 1'b0;
                set_req(2, 1'b0, 1'b0, 32'd1, 32'd1);
            end
            #1;
            check($sformatf("bp_enable%0d", k), 32'(add_bus.add_enable), 0);
            check($sformatf("bp_nogrant%0d", k), 32'(req_ready), 0);
            check($sformatf("bp_outv%0d", k), 32'(add_bus.add_out_valid), 0);
            check_rsp($sformatf("bp_hold%0d", k), 0, 32'h4000_0000);
        end
        step(); rsp_ready = 1'b1; clr_req(2); #1;
        check("bp_release", 32'(add_bus.add_enable), 1);
        check_rsp("bp_a_rsp", 0, 32'h4000_0000);
        step(); #1;
        check("bp_gap", 32'(rsp_valid), 0);
        check("bp_b_emerge", 32'(add_bus.add_out_valid), 1);
        step(); #1;
        check_rsp("bp_b_rsp", 1, 32'h4070_0000);
        step(); #1;
        check("bp_once0", 32'(rsp_valid), 0);
        step(); #1;
        check("bp_once1", 32'(rsp_valid), 0);

        // Reset with two floats in flight and a held response.
        step(); set_req(0, 1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000); #1;
        check("rr_f0_grant", 32'(req_ready), 32'h1);
        step(); clr_req(0); set_req(1, 1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000); #1;
        check("rr_f1_grant", 32'(req_ready), 32'h2);
        step(); clr_req(1); set_req(2, 1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000); #1;
        check("rr_f2_grant", 32'(req_ready), 32'h4);
        step(); clr_req(2);
        step(); rsp_ready = 1'b0; #1;
        check_rsp("rs_held", 0, 32'h4000_0000);
        step(); set_req(3, 1'b0, 1'b0, 32'd1, 32'd1); rstp = 1'b1; #1;
        check("rs_rsp_valid", 32'(rsp_valid), 0);
        check("rs_rsp_id", 32'(rsp_id), 0);
        check("rs_rsp_result", rsp_result, 0);
        check("rs_req_ready", 32'(req_ready), 0);
        check("rs_in_valid", 32'(add_bus.add_in_valid), 0);
        check("rs_tags_clear", 32'(add_bus.add_is_float), 0);
        step(); #1;
        check("rs_hold_ready", 32'(req_ready), 0);
        step(); rstp = 1'b0; clr_req(3); rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            check($sformatf("rs_stale%0d", k), 32'(rsp_valid), 0);
        end
        step(); set_req(0, 1'b0, 1'b1, 32'd3, 32'd1); set_req(3, 1'b0, 1'b0, 32'd10, 32'd10); #1;
        check("rs_ptr_grant", 32'(req_ready), 32'h1);
        step(); clr_req(0); #1;
        check("rs_next_grant", 32'(req_ready), 32'h8);
        check_rsp("rs_sub_rsp", 0, 32'd2);
        step(); clr_req(3); #1;
        check_rsp("rs_add_rsp", 3, 32'd20);
        step(); #1;
        check("rs_drain", 32'(rsp_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
